// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : 640x480@60 VGA timing constants, counter width, the
//                sync/active bundle carried through the video delay line,
//                and a small window-compare helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Counter width: wide enough for 800 columns and 525 rows.
    localparam int c_COUNT_W = 10;

    // Horizontal timing, in pixel clocks.
    localparam int c_TOTAL_COLS    = 800;
    localparam int c_ACTIVE_COLS   = 640;
    localparam int c_H_FRONT_PORCH = 16;
    localparam int c_H_SYNC        = 96;
    localparam int c_H_BACK_PORCH  = 48;

    // Vertical timing, in lines.
    localparam int c_TOTAL_ROWS    = 525;
    localparam int c_ACTIVE_ROWS   = 480;
    localparam int c_V_FRONT_PORCH = 10;
    localparam int c_V_SYNC        = 2;
    localparam int c_V_BACK_PORCH  = 33;

    // Count-aligned sync/active flags, delayed as one bundle so that all
    // three stay in lock-step on their way to the pins.
    typedef struct packed {
        logic hsync;   // active-low
        logic vsync;   // active-low
        logic active;  // visible area
    } sync_bundle_t;

    // Idle (blanked, syncs deasserted) value of the bundle.
    localparam sync_bundle_t c_SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

    // True when v lies in [lo, lo+len-1].
    function automatic logic in_window(input logic [c_COUNT_W-1:0] v,
                                       input int                   lo,
                                       input int                   len);
        return (int'(v) >= lo) && (int'(v) < (lo + len));
    endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/video_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : video_delay_line
//  Description : Fixed-depth shift register. Every stage resets
//                asynchronously to INIT so that nothing queued before a
//                reset can reach the output after it.
//  Ports       : i_Clk  - clock (rising edge)
//                i_Rst  - asynchronous active-high reset
//                i_Data - WIDTH-bit input word
//                o_Data - i_Data delayed by DEPTH clocks (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module video_delay_line #(
    parameter int               WIDTH = 3,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [WIDTH-1:0] i_Data,
    output logic [WIDTH-1:0] o_Data
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("video_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= INIT;
            end
        end else begin
            r_stage[0] <= i_Data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_Data = r_stage[DEPTH-1];

endmodule : video_delay_line
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen
//  Description : VGA timing generator. Produces count-aligned column/row
//                counters, visible-area and frame-start flags for the game
//                logic, and video-aligned syncs and blanked RGB for the pins.
//                The video-aligned outputs lag the counts by VIDEO_DELAY
//                clocks to match the consumer's pipeline.
//  Ports       : i_Clk          - pixel clock
//                i_Rst          - asynchronous active-high reset
//                o_Col_Count    - current column      (count-aligned)
//                o_Row_Count    - current row         (count-aligned)
//                o_Active       - visible-area flag   (count-aligned)
//                o_Frame_Start  - pulse at (0,0)      (count-aligned)
//                i_*_Video      - RGB from game logic
//                o_HSync        - active-low h-sync   (video-aligned)
//                o_VSync        - active-low v-sync   (video-aligned)
//                o_*_Video      - blanked RGB         (video-aligned)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int TOTAL_COLS    = c_TOTAL_COLS,
    parameter int TOTAL_ROWS    = c_TOTAL_ROWS,
    parameter int ACTIVE_COLS   = c_ACTIVE_COLS,
    parameter int ACTIVE_ROWS   = c_ACTIVE_ROWS,
    parameter int H_FRONT_PORCH = c_H_FRONT_PORCH,
    parameter int H_SYNC        = c_H_SYNC,
    parameter int H_BACK_PORCH  = c_H_BACK_PORCH,
    parameter int V_FRONT_PORCH = c_V_FRONT_PORCH,
    parameter int V_SYNC        = c_V_SYNC,
    parameter int V_BACK_PORCH  = c_V_BACK_PORCH,
    parameter int VIDEO_DELAY   = 2
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    output logic [c_COUNT_W-1:0] o_Col_Count,
    output logic [c_COUNT_W-1:0] o_Row_Count,
    output logic                 o_Active,
    output logic                 o_Frame_Start,
    input  logic [3:0]           i_Red_Video,
    input  logic [3:0]           i_Grn_Video,
    input  logic [3:0]           i_Blu_Video,
    output logic                 o_HSync,
    output logic                 o_VSync,
    output logic [3:0]           o_Red_Video,
    output logic [3:0]           o_Grn_Video,
    output logic [3:0]           o_Blu_Video
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH != TOTAL_COLS) begin : g_bad_h_sum
        $error("vga_sync_gen: horizontal segments do not add up to TOTAL_COLS");
    end

    if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH != TOTAL_ROWS) begin : g_bad_v_sum
        $error("vga_sync_gen: vertical segments do not add up to TOTAL_ROWS");
    end

    if (VIDEO_DELAY < 1 || VIDEO_DELAY > 8) begin : g_bad_delay
        $error("vga_sync_gen: VIDEO_DELAY must be in 1..8");
    end

    if (TOTAL_COLS > (1 << c_COUNT_W) || TOTAL_ROWS > (1 << c_COUNT_W)) begin : g_bad_width
        $error("vga_sync_gen: totals exceed the counter width");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [c_COUNT_W-1:0] c_COL_LAST = c_COUNT_W'(TOTAL_COLS - 1);
    localparam logic [c_COUNT_W-1:0] c_ROW_LAST = c_COUNT_W'(TOTAL_ROWS - 1);
    localparam logic [c_COUNT_W-1:0] c_ONE      = c_COUNT_W'(1);
    localparam int                   c_HS_START = ACTIVE_COLS + H_FRONT_PORCH;
    localparam int                   c_VS_START = ACTIVE_ROWS + V_FRONT_PORCH;

    // ------------------------------------------------------------------
    // Count-aligned state
    // ------------------------------------------------------------------
    // r_run is clear through reset and the first edge after it, so that
    // edge loads (0,0) rather than advancing past it: the frame-start
    // pulse for the very first frame is then visible.
    logic                 r_run;
    logic [c_COUNT_W-1:0] r_col;
    logic [c_COUNT_W-1:0] r_row;
    logic                 r_active;
    logic                 r_frame_start;
    sync_bundle_t         r_raw;

    logic [c_COUNT_W-1:0] w_col_nxt;
    logic [c_COUNT_W-1:0] w_row_nxt;
    logic                 w_active_nxt;
    logic                 w_frame_start_nxt;
    logic                 w_hs_nxt;
    logic                 w_vs_nxt;

    // Next counter values. The row steps only on the column wrap and
    // wraps itself on that same clock.
    always_comb begin
        w_col_nxt = '0;
        w_row_nxt = '0;
        if (r_run) begin
            if (r_col == c_COL_LAST) begin
                w_col_nxt = '0;
                w_row_nxt = (r_row == c_ROW_LAST) ? '0 : (r_row + c_ONE);
            end else begin
                w_col_nxt = r_col + c_ONE;
                w_row_nxt = r_row;
            end
        end
    end

    // Flags are decoded from the next counts and registered alongside
    // them, so every count-aligned output changes on the same edge.
    assign w_active_nxt      = (int'(w_col_nxt) < ACTIVE_COLS) && (int'(w_row_nxt) < ACTIVE_ROWS);
    assign w_frame_start_nxt = (w_col_nxt == '0) && (w_row_nxt == '0);
    assign w_hs_nxt          = !in_window(w_col_nxt, c_HS_START, H_SYNC);
    assign w_vs_nxt          = !in_window(w_row_nxt, c_VS_START, V_SYNC);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_run         <= 1'b0;
            r_col         <= '0;
            r_row         <= '0;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
            r_raw         <= c_SYNC_IDLE;
        end else begin
            r_run         <= 1'b1;
            r_col         <= w_col_nxt;
            r_row         <= w_row_nxt;
            r_active      <= w_active_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_raw         <= '{hsync: w_hs_nxt, vsync: w_vs_nxt, active: w_active_nxt};
        end
    end

    assign o_Col_Count   = r_col;
    assign o_Row_Count   = r_row;
    assign o_Active      = r_active;
    assign o_Frame_Start = r_frame_start;

    // ------------------------------------------------------------------
    // Video-aligned path
    // ------------------------------------------------------------------
    // r_raw is already count-aligned, so VIDEO_DELAY further stages give
    // a lag of exactly VIDEO_DELAY clocks relative to the counts.
    sync_bundle_t w_dly;

    video_delay_line #(
        .WIDTH ($bits(sync_bundle_t)),
        .DEPTH (VIDEO_DELAY),
        .INIT  (c_SYNC_IDLE)
    ) u_sync_dly (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Data (r_raw),
        .o_Data (w_dly)
    );

    logic [3:0] r_red;
    logic [3:0] r_grn;
    logic [3:0] r_blu;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
        end else begin
            r_red <= i_Red_Video;
            r_grn <= i_Grn_Video;
            r_blu <= i_Blu_Video;
        end
    end

    assign o_HSync = w_dly.hsync;
    assign o_VSync = w_dly.vsync;

    // Blanking gate sits after the flops: both operands are registers,
    // so no input reaches a pin combinationally, and reset (which clears
    // both) blanks the pins without waiting for an edge.
    assign o_Red_Video = w_dly.active ? r_red : 4'h0;
    assign o_Grn_Video = w_dly.active ? r_grn : 4'h0;
    assign o_Blu_Video = w_dly.active ? r_blu : 4'h0;

endmodule : vga_sync_gen
`default_nettype wire

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter TOTAL_COLS, default 800, meaning horizontal period in pixel clocks.
REQ-002 SHALL have parameter TOTAL_ROWS, default 525, meaning vertical period in lines.
REQ-003 SHALL have parameter ACTIVE_COLS, default 640, meaning visible pixels per line.
REQ-004 SHALL have parameter ACTIVE_ROWS, default 480, meaning visible lines per frame.
REQ-005 SHALL have parameters H_FRONT_PORCH 16, H_SYNC 96, H_BACK_PORCH 48, meaning horizontal blanking segments in clocks.
REQ-006 SHALL have parameters V_FRONT_PORCH 10, V_SYNC 2, V_BACK_PORCH 33, meaning vertical blanking segments in lines.
REQ-007 SHALL have parameter VIDEO_DELAY, default 2, range 1..8, meaning the consumer's pipeline latency in clocks from counts to RGB.
REQ-008 SHALL have the following ports:
- i_Clk, input, 1, pixel clock; the block has one clock, all logic on its rising edge.
- i_Rst, input, 1, reset; asynchronous, active-high.
- o_Col_Count, output, 10, current column (count-aligned).
- o_Row_Count, output, 10, current row (count-aligned).
- o_Active, output, 1, current count is inside the visible area (count-aligned).
- o_Frame_Start, output, 1, one-clock pulse at column 0, row 0 (count-aligned).
- i_Red_Video, i_Grn_Video, i_Blu_Video, input, 4 each, RGB from the game logic.
- o_HSync, output, 1, active-low horizontal sync to the pin (video-aligned).
- o_VSync, output, 1, active-low vertical sync to the pin (video-aligned).
- o_Red_Video, o_Grn_Video, o_Blu_Video, output, 4 each, blanked RGB to the pins (video-aligned).

Function
REQ-009 Column counter SHALL increment every clock and wrap from TOTAL_COLS-1 to 0.
REQ-010 Row counter SHALL increment only on the column wrap, and SHALL wrap from TOTAL_ROWS-1 to 0 on that same clock.
REQ-011 o_Active SHALL be 1 exactly when col < ACTIVE_COLS and row < ACTIVE_ROWS, in the same cycle as the counts.
REQ-012 o_Frame_Start SHALL be 1 for exactly one clock per frame, in the cycle the counts are (0,0).
REQ-013 The raw horizontal sync SHALL be low for col in [ACTIVE_COLS+H_FRONT_PORCH, ACTIVE_COLS+H_FRONT_PORCH+H_SYNC-1] (default 656..751), and high otherwise.
REQ-014 The raw vertical sync SHALL be low for row in [ACTIVE_ROWS+V_FRONT_PORCH, ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC-1] (default 490..491), for every column of those rows.
REQ-015 Raw HSync, raw VSync and o_Active SHALL pass through a delay line of VIDEO_DELAY clocks, so that o_HSync and o_VSync lag the counts by exactly VIDEO_DELAY clocks.
REQ-016 RGB input SHALL be registered once.
REQ-017 Registered RGB SHALL be forced to 0 whenever the delayed active flag is 0.
REQ-018 Output RGB SHALL therefore correspond to the counts presented VIDEO_DELAY clocks earlier.
REQ-019 Sums SHALL hold: ACTIVE+FRONT+SYNC+BACK equals TOTAL on both axes; a violation SHALL produce an elaboration or simulation $error.
REQ-020 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Reset
REQ-021 While i_Rst=1:
- counts SHALL be 0.
- o_Active and o_Frame_Start SHALL be 0.
- o_HSync and o_VSync SHALL be 1.
- RGB outputs SHALL be 0.
- all delay stages SHALL be cleared to the inactive state.
REQ-022 On the first clock edge after reset release, counts SHALL present (0,0) with o_Active=1 and o_Frame_Start=1.
REQ-023 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock, and SHALL discard in-flight delay-line contents.

Structure
REQ-024 Package vga_timing_pkg SHALL hold the 640x480@60 constants (totals, actives, porches, sync widths) and the count width (10).
REQ-025 Sub-module video_delay_line SHALL implement the delay: parameters WIDTH and DEPTH, reset to a parameterised INIT value, used once for the sync/active bundle.

Verification
REQ-026 Release reset, run 2 frames:
- o_Frame_Start pulses exactly twice, 420000 clocks apart.
- o_Row_Count 0..524 with no skipped or repeated values.
REQ-027 Count from the first active clock, over one line:
- o_HSync is low for 96 consecutive clocks, starting at count col=656 plus 2 clocks.
- o_HSync is high for the other 704 clocks.
REQ-028 Over one frame:
- o_VSync is low for exactly 1600 clocks.
- the low window starts at row 490, col 0, plus 2 clocks.
REQ-029 Drive i_Red_Video=4'hF constantly:
- o_Red_Video is F for exactly 640x480 clocks per frame.
- it is 0 in all blanking.
- the first F appears 2 clocks after o_Frame_Start.
REQ-030 Assert i_Rst at col 700, row 300, then release:
- asynchronously o_HSync=1 and RGB=0.
- the next edge gives (0,0) with o_Frame_Start=1.
- no stale sync pulse emerges from the delay line.
REQ-031 With VIDEO_DELAY=1 and small parameters (TOTAL 10x6, ACTIVE 4x3, porches 1/2/3 and 1/1/1):
- row wraps 5 to 0 on the col 9 to 0 edge.
- sync windows are col 5..6 and row 4.
